// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - fetch-stage address map and state encodings
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_7000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_HALT  = 2'd2
    } if_state_t;

    // A PC outside [RESET_PC, TEXT_END) is not fetchable text.
    function automatic logic pc_out_of_text(input logic [31:0] addr);
        return (addr >= TEXT_END) || (addr < RESET_PC);
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// rtl/if_fetch_unit_skid.sv - one-entry {valid, instr, pc} buffer for stalled fetches
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= 32'd0;
            pc    <= 32'd0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC, instruction-memory requester and IF/ID latch
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted
);

    if_state_t   state, state_n;
    logic [31:0] pc, pc_n;
    logic        kill, kill_n;
    logic [31:0] kill_pc, kill_pc_n;

    logic        transfer, redirect;
    logic [31:0] target, npc_aligned;
    logic        pc_upd;

    logic        id_load, id_kill;
    logic [31:0] id_src_instr, id_src_pc;

    logic        skid_load, skid_drain, skid_clear;
    logic        skid_valid;
    logic [31:0] skid_instr, skid_pc;

    assign imem_req  = (state == IF_FETCH);
    assign imem_addr = pc;
    assign pc_if     = pc;
    assign halted    = (state == IF_HALT);

    assign transfer    = imem_req & imem_ready;
    assign redirect    = exc_req | eret_req;
    assign target      = exc_req ? EXC_VECTOR : (epc & ~32'd3);
    assign npc_aligned = npc & ~32'd3;

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        kill_n       = kill;
        kill_pc_n    = kill_pc;
        pc_upd       = 1'b0;
        id_load      = 1'b0;
        id_kill      = 1'b0;
        id_src_instr = imem_rdata;
        id_src_pc    = pc;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        unique case (state)
            IF_FETCH: begin
                if (redirect) begin
                    id_kill    = 1'b1;
                    skid_clear = 1'b1;
                    if (transfer) begin
                        pc_n   = target;
                        kill_n = 1'b0;
                        pc_upd = 1'b1;
                    end else begin
                        // Request must stay up on the old address; remember where to go.
                        kill_n    = 1'b1;
                        kill_pc_n = target;
                    end
                end else if (transfer && kill) begin
                    pc_n    = kill_pc;
                    kill_n  = 1'b0;
                    pc_upd  = 1'b1;
                    id_kill = !stall;
                end else if (transfer && stall) begin
                    skid_load = 1'b1;
                    state_n   = IF_HOLD;
                end else if (transfer) begin
                    id_load = 1'b1;
                    pc_n    = npc_aligned;
                    pc_upd  = 1'b1;
                end else begin
                    id_kill = !stall;
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    id_kill    = 1'b1;
                    skid_clear = 1'b1;
                    pc_n       = target;
                    pc_upd     = 1'b1;
                end else if (!stall) begin
                    id_load      = skid_valid;
                    id_kill      = !skid_valid;
                    id_src_instr = skid_instr;
                    id_src_pc    = skid_pc;
                    skid_drain   = 1'b1;
                    pc_n         = npc_aligned;
                    pc_upd       = 1'b1;
                end
            end
            IF_HALT: begin
                if (redirect) begin
                    id_kill    = 1'b1;
                    skid_clear = 1'b1;
                    kill_n     = 1'b0;
                    pc_n       = target;
                    pc_upd     = 1'b1;
                end else begin
                    id_kill = !stall;
                end
            end
            default: begin
                state_n = IF_HALT;
            end
        endcase

        if (pc_upd) begin
            state_n = pc_out_of_text(pc_n) ? IF_HALT : IF_FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IF_FETCH;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            kill_pc  <= 32'd0;
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc    <= 32'd0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            kill    <= kill_n;
            kill_pc <= kill_pc_n;
            if (id_load) begin
                id_valid <= 1'b1;
                id_instr <= id_src_instr;
                id_pc    <= id_src_pc;
            end else if (id_kill) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;

    logic        npc_ovr;
    logic [31:0] npc_val;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        ovr;
        logic [31:0] nval;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc;
        logic        e_halt;
    } vec_t;

    vec_t vecs[26];

    if_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_if      (pc_if),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);
    assign npc        = npc_ovr ? npc_val : pc_if + 32'd4;

    function automatic vec_t mk(input logic s, input logic r, input logic x, input logic e,
                                input logic [31:0] ep, input logic ov, input logic [31:0] nv,
                                input logic rq, input logic [31:0] ad, input logic iv,
                                input logic [31:0] ip, input logic h);
        vec_t v;
        v.stall = s;  v.ready = r;  v.exc = x;  v.eret = e;  v.epc = ep;
        v.ovr = ov;   v.nval = nv;  v.e_req = rq; v.e_addr = ad;
        v.e_idv = iv; v.e_idpc = ip; v.e_halt = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        stall      = v.stall;
        imem_ready = v.ready;
        exc_req    = v.exc;
        eret_req   = v.eret;
        epc        = v.epc;
        npc_ovr    = v.ovr;
        npc_val    = v.nval;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //            stall rdy exc eret epc           ovr npc          req addr          idv idpc          halt
        vecs[0]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3000, 0, 32'h0,         0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3004, 1, 32'h0000_3000, 0);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3008, 1, 32'h0000_3004, 0);
        vecs[3]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0000_3008, 1, 32'h0000_3004, 0);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0000_3008, 1, 32'h0000_3004, 0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_300C, 1, 32'h0000_3008, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3010, 1, 32'h0000_300C, 0);
        vecs[7]  = mk(0, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3010, 0, 32'h0,         0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3010, 0, 32'h0,         0);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3010, 0, 32'h0,         0);
        vecs[10] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_4180, 0, 32'h0,         0);
        vecs[11] = mk(0, 1, 1, 1, 32'h0000_3100, 0, 32'h0,        1, 32'h0000_4184, 1, 32'h0000_4180, 0);
        vecs[12] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_7000, 1, 32'h0000_4180, 0, 32'h0,        0);
        vecs[13] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0000_7000, 1, 32'h0000_4180, 1);
        vecs[14] = mk(0, 1, 0, 1, 32'h0000_3022, 0, 32'h0,        0, 32'h0000_7000, 0, 32'h0,         1);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3020, 0, 32'h0,         0);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3024, 1, 32'h0000_3020, 0);
        vecs[17] = mk(0, 0, 0, 1, 32'h0000_3100, 0, 32'h0,        1, 32'h0000_3024, 0, 32'h0,         0);
        vecs[18] = mk(0, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3024, 0, 32'h0,         0);
        vecs[19] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3024, 0, 32'h0,         0);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_4180, 0, 32'h0,         0);
        vecs[21] = mk(0, 1, 0, 1, 32'h0000_1000, 0, 32'h0,        1, 32'h0000_4184, 1, 32'h0000_4180, 0);
        vecs[22] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0000_1000, 0, 32'h0,         1);
        vecs[23] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0000_1000, 0, 32'h0,         1);
        vecs[24] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_4180, 0, 32'h0,         0);
        vecs[25] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_4184, 1, 32'h0000_4180, 0);

        reset = 1'b0;
        apply(vecs[0]);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc_if",    pc_if,            32'h0000_3000);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr,         32'd0);
        chk("rst_id_pc",    id_pc,            32'd0);
        chk("rst_halted",   {31'd0, halted},  32'd0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_req", i),    {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),   imem_addr,         vecs[i].e_addr);
            chk($sformatf("v%0d_pc_if", i),  pc_if,             vecs[i].e_addr);
            chk($sformatf("v%0d_idv", i),    {31'd0, id_valid}, {31'd0, vecs[i].e_idv});
            chk($sformatf("v%0d_halted", i), {31'd0, halted},   {31'd0, vecs[i].e_halt});
            if (vecs[i].e_idv) begin
                chk($sformatf("v%0d_idpc", i),  id_pc,    vecs[i].e_idpc);
                chk($sformatf("v%0d_instr", i), id_instr, word_at(vecs[i].e_idpc));
            end
        end

        // Reset asserted mid-request while memory is not ready.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc_if",  pc_if,             32'h0000_3000);
        chk("mid_rst_idv",    {31'd0, id_valid}, 32'd0);
        chk("mid_rst_id_pc",  id_pc,             32'd0);
        chk("mid_rst_instr",  id_instr,          32'd0);
        chk("mid_rst_halted", {31'd0, halted},   32'd0);

        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        npc_ovr    = 1'b0;
        #1;
        chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr,         32'h0000_3000);
        @(negedge clk);
        #1;
        chk("post_rst_addr2", imem_addr,         32'h0000_3004);
        chk("post_rst_idv",   {31'd0, id_valid}, 32'd1);
        chk("post_rst_idpc",  id_pc,             32'h0000_3000);
        chk("post_rst_instr", id_instr,          32'hC0DE_3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
